rd_wr_window_monitor: RTL and testbench

- Synthesizable multi-channel checker for read/write exclusivity. It generalises the "on rising rd, no wr while rd held for N cycles" property into hardware.
- Per channel: a rising edge of rd opens a WIN_LEN-cycle window; rd must stay high and wr must stay low throughout.
- Produces per-channel pass/fail pulses, error codes, sticky flags and saturating counters.
- Sits beside bus/memory ports as a run-time protocol monitor; its outputs are also used as bench scoreboards.

---
 rtl/rwmon_pkg.sv | 17 +
 rtl/rd_wr_window_monitor_if.sv | 31 +++
 rtl/rwmon_chan.sv | 96 +++++++++
 rtl/rd_wr_window_monitor.sv | 60 ++++++
 tb/tb_rd_wr_window_monitor.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rwmon_pkg.sv
// Shared types for the rd/wr window monitor: verdict codes and channel FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rwmon_pkg;

   typedef enum logic [1:0] {
      ERR_NONE        = 2'b00,
      ERR_RD_DROP     = 2'b01,
      ERR_WR_CONFLICT = 2'b10
   } err_t;

   typedef enum logic {
      ST_IDLE,
      ST_WIN
   } state_t;

endpackage

// File: rtl/rd_wr_window_monitor_if.sv
// Bundle of the monitored rd/wr strobes, clear and all monitor verdict outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the monitor observes and never stalls the bus it watches.
interface rd_wr_window_monitor_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
);
   logic [NUM_CH-1:0]       rd;
   logic [NUM_CH-1:0]       wr;
   logic                    clr;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH-1:0]       pass;
   logic [NUM_CH-1:0]       fail;
   logic [2*NUM_CH-1:0]     err_code;
   logic [NUM_CH-1:0]       fail_sticky;
   logic                    any_fail;
   logic [NUM_CH*CNT_W-1:0] pass_cnt;
   logic [NUM_CH*CNT_W-1:0] fail_cnt;

   // Stimulus side: drives the strobes, reads the verdicts.
   modport master (
      output rd, wr, clr,
      input  busy, pass, fail, err_code, fail_sticky, any_fail, pass_cnt, fail_cnt
   );

   // Monitor side.
   modport slave (
      input  rd, wr, clr,
      output busy, pass, fail, err_code, fail_sticky, any_fail, pass_cnt, fail_cnt
   );
endinterface

// File: rtl/rwmon_chan.sv
// One channel: rd rise opens a WIN_LEN-cycle window in which rd must hold and wr stay low.
// Latency: verdict (pass/fail/err_code) registered one cycle after the deciding cycle.
// Backpressure: none; purely observational.
module rwmon_chan
   import rwmon_pkg::*;
#(
   parameter int WIN_LEN = 2,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd,
   input  logic             wr,
   input  logic             clr,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output err_t             err_code,
   output logic             fail_sticky,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);
   localparam int               IDX_W = $clog2(WIN_LEN + 1);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIN_LEN - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             rd_q;

   logic rise;
   logic chk;
   logic at_last;
   logic v_conf;
   logic v_drop;
   logic v_pass;

   // A rise is only meaningful while idle; the rise cycle itself is window cycle 0.
   assign rise    = rd & ~rd_q & (state == ST_IDLE);
   assign chk     = rise | (state == ST_WIN);
   assign at_last = rise ? (WIN_LEN == 1) : (idx == LAST);
   // A write anywhere in the window outranks a dropped read.
   assign v_conf  = chk & wr;
   assign v_drop  = chk & ~wr & ~rd;
   assign v_pass  = chk & ~wr & rd & at_last;

   // Window FSM with registered verdict and busy outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         idx      <= '0;
         rd_q     <= 1'b0;
         busy     <= 1'b0;
         pass     <= 1'b0;
         fail     <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         rd_q     <= rd;
         busy     <= chk;
         pass     <= v_pass;
         fail     <= v_conf | v_drop;
         err_code <= v_conf ? ERR_WR_CONFLICT : (v_drop ? ERR_RD_DROP : ERR_NONE);
         case (state)
            ST_IDLE: begin
               // Single-cycle windows are decided on the rise and never enter ST_WIN.
               if (rise && !v_conf && !v_pass) begin
                  state <= ST_WIN;
                  idx   <= IDX_W'(1);
               end
            end
            ST_WIN: begin
               if (v_conf || v_drop || v_pass) state <= ST_IDLE;
               else                            idx   <= idx + IDX_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Saturating counters and sticky flag; clear wins over a same-cycle update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         fail_sticky <= 1'b0;
      end else if (clr) begin
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         fail_sticky <= 1'b0;
      end else begin
         if (v_pass && (pass_cnt != '1))            pass_cnt    <= pass_cnt + CNT_W'(1);
         if ((v_conf || v_drop) && (fail_cnt != '1)) fail_cnt   <= fail_cnt + CNT_W'(1);
         if (v_conf || v_drop)                       fail_sticky <= 1'b1;
      end
   end

endmodule

// File: rtl/rd_wr_window_monitor.sv
// Multi-channel rd/wr exclusivity monitor; NUM_CH independent window checkers.
// Latency: verdicts one cycle after the deciding cycle; a clean window from rise t passes at t+WIN_LEN.
// Backpressure: none; observes only. Optional simulation trace under macro RWMON_TRACE_EN.
module rd_wr_window_monitor #(
   parameter int NUM_CH  = 4,
   parameter int WIN_LEN = 2,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   rd_wr_window_monitor_if.slave  mon
);
   wire [NUM_CH-1:0]       busy_w;
   wire [NUM_CH-1:0]       pass_w;
   wire [NUM_CH-1:0]       fail_w;
   wire [2*NUM_CH-1:0]     err_w;
   wire [NUM_CH-1:0]       sticky_w;
   wire [NUM_CH*CNT_W-1:0] pcnt_w;
   wire [NUM_CH*CNT_W-1:0] fcnt_w;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      rwmon_chan #(
         .WIN_LEN (WIN_LEN),
         .CNT_W   (CNT_W)
      ) u_chan (
         .clk         (clk),
         .rst_n       (rst_n),
         .rd          (mon.rd[g]),
         .wr          (mon.wr[g]),
         .clr         (mon.clr),
         .busy        (busy_w[g]),
         .pass        (pass_w[g]),
         .fail        (fail_w[g]),
         .err_code    (err_w[2*g +: 2]),
         .fail_sticky (sticky_w[g]),
         .pass_cnt    (pcnt_w[g*CNT_W +: CNT_W]),
         .fail_cnt    (fcnt_w[g*CNT_W +: CNT_W])
      );

`ifdef RWMON_TRACE_EN
      // Report each verdict and guard against a channel claiming pass and fail at once.
      always @(posedge clk) begin
         if (pass_w[g]) $info("ch%0d pass at %0t", g, $time);
         if (fail_w[g]) $error("ch%0d fail code %0b at %0t", g, err_w[2*g +: 2], $time);
         assert (!(pass_w[g] && fail_w[g]))
            else $error("ch%0d pass and fail together at %0t", g, $time);
      end
`endif
   end

   assign mon.busy        = busy_w;
   assign mon.pass        = pass_w;
   assign mon.fail        = fail_w;
   assign mon.err_code    = err_w;
   assign mon.fail_sticky = sticky_w;
   assign mon.any_fail    = |sticky_w;
   assign mon.pass_cnt    = pcnt_w;
   assign mon.fail_cnt    = fcnt_w;

endmodule

// File: tb/tb_rd_wr_window_monitor.sv
// Bench for rd_wr_window_monitor: directed scenarios on three builds plus a random run
// checked against a time-indexed window model of the main (default) build.
module tb_rd_wr_window_monitor;
   localparam int NC = 4;
   localparam int WL = 2;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   rd_wr_window_monitor_if #(.NUM_CH(NC), .CNT_W(CW)) m ();
   rd_wr_window_monitor_if #(.NUM_CH(1),  .CNT_W(2))  s ();
   rd_wr_window_monitor_if #(.NUM_CH(2),  .CNT_W(CW)) w ();

   rd_wr_window_monitor #(.NUM_CH(NC), .WIN_LEN(WL), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .mon(m.slave));
   rd_wr_window_monitor #(.NUM_CH(1), .WIN_LEN(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .mon(s.slave));
   rd_wr_window_monitor #(.NUM_CH(2), .WIN_LEN(1), .CNT_W(CW)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .mon(w.slave));

   // ---------------- reference model of the main build ----------------
   // Each channel remembers whether a window is open and the cycle number it opened on;
   // the age of the window (now - start) says which window cycle is being judged.
   logic [NC-1:0]   mr_open, mr_rdprev, me_busy, me_pass, me_fail, me_sticky;
   logic [2*NC-1:0] me_code;
   int              mr_start [NC];
   int              me_pcnt  [NC];
   int              me_fcnt  [NC];
   int              mr_cyc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mr_open   <= '0;
         mr_rdprev <= '0;
         me_busy   <= '0;
         me_pass   <= '0;
         me_fail   <= '0;
         me_sticky <= '0;
         me_code   <= '0;
         mr_cyc    <= 0;
         for (int c = 0; c < NC; c++) begin
            mr_start[c] <= 0;
            me_pcnt[c]  <= 0;
            me_fcnt[c]  <= 0;
         end
      end else begin
         mr_cyc <= mr_cyc + 1;
         for (int c = 0; c < NC; c++) begin
            automatic logic       open_n = mr_open[c];
            automatic int         st     = mr_start[c];
            automatic logic       vp     = 1'b0;
            automatic logic       vf     = 1'b0;
            automatic logic [1:0] code   = 2'b00;
            if (!open_n && m.rd[c] && !mr_rdprev[c]) begin
               open_n = 1'b1;
               st     = mr_cyc;
            end
            if (open_n) begin
               if (m.wr[c])                  begin vf = 1'b1; code = 2'b10; open_n = 1'b0; end
               else if (!m.rd[c])            begin vf = 1'b1; code = 2'b01; open_n = 1'b0; end
               else if (mr_cyc - st == WL-1) begin vp = 1'b1; open_n = 1'b0; end
            end
            mr_open[c]        <= open_n;
            mr_start[c]       <= st;
            mr_rdprev[c]      <= m.rd[c];
            me_busy[c]        <= open_n | vp | vf;
            me_pass[c]        <= vp;
            me_fail[c]        <= vf;
            me_code[2*c +: 2] <= code;
            if (m.clr) begin
               me_pcnt[c]   <= 0;
               me_fcnt[c]   <= 0;
               me_sticky[c] <= 1'b0;
            end else begin
               if (vp && me_pcnt[c] < CMAX) me_pcnt[c] <= me_pcnt[c] + 1;
               if (vf && me_fcnt[c] < CMAX) me_fcnt[c] <= me_fcnt[c] + 1;
               if (vf) me_sticky[c] <= 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      m.rd = '0; m.wr = '0; m.clr = 1'b0;
      s.rd = '0; s.wr = '0; s.clr = 1'b0;
      w.rd = '0; w.wr = '0; w.clr = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (m.busy !== '0)        begin n_bad++; $display("FAIL reset_busy: got %h want 0", m.busy); end
      n_cmp++; if (m.pass !== '0)        begin n_bad++; $display("FAIL reset_pass: got %h want 0", m.pass); end
      n_cmp++; if (m.fail !== '0)        begin n_bad++; $display("FAIL reset_fail: got %h want 0", m.fail); end
      n_cmp++; if (m.err_code !== '0)    begin n_bad++; $display("FAIL reset_err: got %h want 0", m.err_code); end
      n_cmp++; if (m.fail_sticky !== '0) begin n_bad++; $display("FAIL reset_sticky: got %h want 0", m.fail_sticky); end
      n_cmp++; if (m.any_fail !== 1'b0)  begin n_bad++; $display("FAIL reset_any_fail: got %b want 0", m.any_fail); end
      n_cmp++; if (m.pass_cnt !== '0)    begin n_bad++; $display("FAIL reset_pass_cnt: got %h want 0", m.pass_cnt); end
      n_cmp++; if (m.fail_cnt !== '0)    begin n_bad++; $display("FAIL reset_fail_cnt: got %h want 0", m.fail_cnt); end
   endtask

   task automatic test_clean_window();
      m.rd[0] = 1'b1;
      tick();
      n_cmp++; if (m.busy[0] !== 1'b1) begin n_bad++; $display("FAIL clean_busy_w1: got %b want 1", m.busy[0]); end
      n_cmp++; if (m.pass[0] !== 1'b0) begin n_bad++; $display("FAIL clean_early_pass: got %b want 0", m.pass[0]); end
      tick();
      n_cmp++; if (m.pass[0] !== 1'b1) begin n_bad++; $display("FAIL clean_pass: got %b want 1", m.pass[0]); end
      n_cmp++; if (m.fail[0] !== 1'b0) begin n_bad++; $display("FAIL clean_fail: got %b want 0", m.fail[0]); end
      n_cmp++; if (m.busy[0] !== 1'b1) begin n_bad++; $display("FAIL clean_busy_verdict: got %b want 1", m.busy[0]); end
      m.rd[0] = 1'b0;
      tick();
      n_cmp++; if (m.pass[0] !== 1'b0) begin n_bad++; $display("FAIL clean_pass_width: got %b want 0", m.pass[0]); end
      n_cmp++; if (m.busy[0] !== 1'b0) begin n_bad++; $display("FAIL clean_busy_end: got %b want 0", m.busy[0]); end
      n_cmp++; if (m.pass_cnt[7:0] !== 8'd1) begin n_bad++; $display("FAIL clean_pass_cnt: got %0d want 1", m.pass_cnt[7:0]); end
   endtask

   task automatic test_conflict();
      m.rd[0] = 1'b1;
      tick();
      m.wr[0] = 1'b1;
      tick();
      n_cmp++; if (m.fail[0] !== 1'b1)        begin n_bad++; $display("FAIL conf_fail: got %b want 1", m.fail[0]); end
      n_cmp++; if (m.err_code[1:0] !== 2'b10) begin n_bad++; $display("FAIL conf_code: got %b want 10", m.err_code[1:0]); end
      n_cmp++; if (m.pass[0] !== 1'b0)        begin n_bad++; $display("FAIL conf_pass: got %b want 0", m.pass[0]); end
      m.rd[0] = 1'b0; m.wr[0] = 1'b0;
      tick();
      n_cmp++; if (m.fail_sticky[0] !== 1'b1) begin n_bad++; $display("FAIL conf_sticky: got %b want 1", m.fail_sticky[0]); end
      n_cmp++; if (m.any_fail !== 1'b1)       begin n_bad++; $display("FAIL conf_any_fail: got %b want 1", m.any_fail); end
      n_cmp++; if (m.fail_cnt[7:0] !== 8'd1)  begin n_bad++; $display("FAIL conf_fail_cnt: got %0d want 1", m.fail_cnt[7:0]); end
      n_cmp++; if (m.err_code[1:0] !== 2'b00) begin n_bad++; $display("FAIL conf_code_clear: got %b want 00", m.err_code[1:0]); end
   endtask

   task automatic test_drop_priority();
      m.rd[0] = 1'b1;
      tick();
      m.rd[0] = 1'b0;
      tick();
      n_cmp++; if (m.fail[0] !== 1'b1)        begin n_bad++; $display("FAIL drop_fail: got %b want 1", m.fail[0]); end
      n_cmp++; if (m.err_code[1:0] !== 2'b01) begin n_bad++; $display("FAIL drop_code: got %b want 01", m.err_code[1:0]); end
      tick();
      m.rd[0] = 1'b1;
      tick();
      m.rd[0] = 1'b0; m.wr[0] = 1'b1;
      tick();
      n_cmp++; if (m.err_code[1:0] !== 2'b10) begin n_bad++; $display("FAIL prio_code: got %b want 10", m.err_code[1:0]); end
      m.wr[0] = 1'b0;
      tick();
      n_cmp++; if (m.fail_cnt[7:0] !== 8'd3)  begin n_bad++; $display("FAIL prio_fail_cnt: got %0d want 3", m.fail_cnt[7:0]); end
   endtask

   task automatic test_retrigger();
      int np = 0;
      int nf = 0;
      m.rd[0] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         np += int'(m.pass[0]);
         nf += int'(m.fail[0]);
         if (i == 4) m.rd[0] = 1'b0;
      end
      n_cmp++; if (np !== 1) begin n_bad++; $display("FAIL retrig_passes: got %0d want 1", np); end
      n_cmp++; if (nf !== 0) begin n_bad++; $display("FAIL retrig_fails: got %0d want 0", nf); end
      n_cmp++; if (m.pass_cnt[7:0] !== 8'd2) begin n_bad++; $display("FAIL retrig_pass_cnt: got %0d want 2", m.pass_cnt[7:0]); end
   endtask

   task automatic test_multichannel();
      m.rd[1] = 1'b1; m.rd[2] = 1'b1;
      tick();
      m.wr[1] = 1'b1;
      tick();
      n_cmp++; if (m.fail[1] !== 1'b1)        begin n_bad++; $display("FAIL multi_fail1: got %b want 1", m.fail[1]); end
      n_cmp++; if (m.err_code[3:2] !== 2'b10) begin n_bad++; $display("FAIL multi_code1: got %b want 10", m.err_code[3:2]); end
      n_cmp++; if (m.pass[1] !== 1'b0)        begin n_bad++; $display("FAIL multi_pass1: got %b want 0", m.pass[1]); end
      n_cmp++; if (m.pass[2] !== 1'b1)        begin n_bad++; $display("FAIL multi_pass2: got %b want 1", m.pass[2]); end
      n_cmp++; if (m.fail[2] !== 1'b0)        begin n_bad++; $display("FAIL multi_fail2: got %b want 0", m.fail[2]); end
      n_cmp++; if (m.err_code[5:4] !== 2'b00) begin n_bad++; $display("FAIL multi_code2: got %b want 00", m.err_code[5:4]); end
      m.rd = '0; m.wr = '0;
      tick();
   endtask

   task automatic test_clear();
      m.clr = 1'b1;
      tick();
      m.clr = 1'b0;
      n_cmp++; if (m.fail_sticky !== '0) begin n_bad++; $display("FAIL clr_sticky: got %h want 0", m.fail_sticky); end
      n_cmp++; if (m.any_fail !== 1'b0)  begin n_bad++; $display("FAIL clr_any_fail: got %b want 0", m.any_fail); end
      n_cmp++; if (m.fail_cnt !== '0)    begin n_bad++; $display("FAIL clr_fail_cnt: got %h want 0", m.fail_cnt); end
      n_cmp++; if (m.pass_cnt !== '0)    begin n_bad++; $display("FAIL clr_pass_cnt: got %h want 0", m.pass_cnt); end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 5; k++) begin
         s.rd = 1'b1;
         tick();
         tick();
         s.rd = 1'b0;
         tick();
      end
      n_cmp++; if (s.pass_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_pass_cnt: got %0d want 3", s.pass_cnt); end
      s.rd = 1'b1;
      tick();
      s.clr = 1'b1;
      tick();
      n_cmp++; if (s.pass !== 1'b1)     begin n_bad++; $display("FAIL sat_clr_pass: got %b want 1", s.pass); end
      n_cmp++; if (s.pass_cnt !== 2'd0) begin n_bad++; $display("FAIL sat_clr_cnt: got %0d want 0", s.pass_cnt); end
      s.clr = 1'b0; s.rd = 1'b0;
      tick();
   endtask

   task automatic test_win_len1();
      w.rd[0] = 1'b1;
      tick();
      n_cmp++; if (w.pass[0] !== 1'b1) begin n_bad++; $display("FAIL w1_pass: got %b want 1", w.pass[0]); end
      n_cmp++; if (w.busy[0] !== 1'b1) begin n_bad++; $display("FAIL w1_busy: got %b want 1", w.busy[0]); end
      w.rd[0] = 1'b0;
      tick();
      n_cmp++; if (w.pass[0] !== 1'b0) begin n_bad++; $display("FAIL w1_pass_end: got %b want 0", w.pass[0]); end
      n_cmp++; if (w.busy[0] !== 1'b0) begin n_bad++; $display("FAIL w1_busy_end: got %b want 0", w.busy[0]); end
      w.rd[1] = 1'b1; w.wr[1] = 1'b1;
      tick();
      n_cmp++; if (w.fail[1] !== 1'b1)        begin n_bad++; $display("FAIL w1_fail: got %b want 1", w.fail[1]); end
      n_cmp++; if (w.err_code[3:2] !== 2'b10) begin n_bad++; $display("FAIL w1_code: got %b want 10", w.err_code[3:2]); end
      w.rd = '0; w.wr = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      int nv = 0;
      m.rd[3] = 1'b1;
      tick();
      n_cmp++; if (m.busy[3] !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_open: got %b want 1", m.busy[3]); end
      #2;
      rst_n   = 1'b0;
      m.rd[3] = 1'b0;
      #1;
      n_cmp++; if (m.busy[3] !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_async: got %b want 0", m.busy[3]); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         nv += int'(m.pass[3]) + int'(m.fail[3]);
      end
      n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL rmid_verdicts: got %0d want 0", nv); end
   endtask

   task automatic test_random();
      logic [NC*CW-1:0] ep;
      logic [NC*CW-1:0] ef;
      for (int n = 0; n < 400; n++) begin
         tick();
         for (int c = 0; c < NC; c++) begin
            ep[c*CW +: CW] = CW'(me_pcnt[c]);
            ef[c*CW +: CW] = CW'(me_fcnt[c]);
         end
         n_cmp++; if (m.busy !== me_busy)        begin n_bad++; $display("FAIL rnd_busy @%0d: got %h want %h", n, m.busy, me_busy); end
         n_cmp++; if (m.pass !== me_pass)        begin n_bad++; $display("FAIL rnd_pass @%0d: got %h want %h", n, m.pass, me_pass); end
         n_cmp++; if (m.fail !== me_fail)        begin n_bad++; $display("FAIL rnd_fail @%0d: got %h want %h", n, m.fail, me_fail); end
         n_cmp++; if (m.err_code !== me_code)    begin n_bad++; $display("FAIL rnd_err @%0d: got %h want %h", n, m.err_code, me_code); end
         n_cmp++; if (m.fail_sticky !== me_sticky) begin n_bad++; $display("FAIL rnd_sticky @%0d: got %h want %h", n, m.fail_sticky, me_sticky); end
         n_cmp++; if (m.any_fail !== (|me_sticky)) begin n_bad++; $display("FAIL rnd_any_fail @%0d: got %b want %b", n, m.any_fail, |me_sticky); end
         n_cmp++; if (m.pass_cnt !== ep)         begin n_bad++; $display("FAIL rnd_pass_cnt @%0d: got %h want %h", n, m.pass_cnt, ep); end
         n_cmp++; if (m.fail_cnt !== ef)         begin n_bad++; $display("FAIL rnd_fail_cnt @%0d: got %h want %h", n, m.fail_cnt, ef); end
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(2, 0) == 0) m.rd[c] = ~m.rd[c];
            m.wr[c] = ($urandom_range(5, 0) == 0);
         end
         m.clr = ($urandom_range(40, 0) == 0);
      end
      m.rd = '0; m.wr = '0; m.clr = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_clean_window();
      test_conflict();
      test_drop_priority();
      test_retrigger();
      test_multichannel();
      test_clear();
      test_saturation();
      test_win_len1();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
